ksa_multiword_adder: RTL

- Sequential wide adder: adds WIDTH-bit operands by reusing one SLICE-bit Kogge-Stone adder over WIDTH/SLICE consecutive cycles.
- A registered carry chains the slices, least-significant slice first.
- Sits between operand producers and result consumers, with valid/ready on both sides.
- Wraps one ksa_nbit #(SLICE) instance, port order (A, B, Ci, Co, S).

---
 rtl/ksa_multiword_adder_if.sv | 47 ++++
 rtl/ksa_multiword_adder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ksa_multiword_adder_if.sv
// ---------------------------------------------------------------------------
// ksa_multiword_adder_if
// Operand/result bus for the sequential multi-word adder.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds in_valid, a, b and ci stable until it sees
// in_ready. The consumer observes out_valid. sum and co stay stable while
// out_valid is high. The result is released on the edge where out_ready is
// high. Neither side may make its valid depend on the other side's ready.
//
// Signals
//   in_valid  : producer -> adder, operands valid
//   in_ready  : adder -> producer, operands can be accepted
//   a, b      : producer -> adder, WIDTH-bit unsigned operands
//   ci        : producer -> adder, carry-in to the least-significant slice
//   out_valid : adder -> consumer, sum/co valid
//   out_ready : consumer -> adder, result accepted
//   sum       : adder -> consumer, (a + b + ci) mod 2^WIDTH
//   co        : adder -> consumer, carry-out of the full-width addition
//
// Modports
//   master : producer/consumer side (testbench or surrounding logic)
//   slave  : adder side
// ---------------------------------------------------------------------------
interface ksa_multiword_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/ksa_multiword_adder.sv
// ---------------------------------------------------------------------------
// ksa_multiword_adder
// Sequential wide adder. A WIDTH-bit addition is built from WIDTH/SLICE passes
// through one SLICE-bit Kogge-Stone adder, least-significant slice first. The
// carry between slices travels through a register, so no combinational path
// spans two slices.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous, active-high reset
//   bus         : ksa_multiword_adder_if.slave, operand/result handshake bus
//   o_dbg_state : current FSM state (0 IDLE, 1 RUN, 2 DONE), debug only
//
// Timing
//   Operands are accepted at edge E0. out_valid is high from edge E0+NSLICES.
//   The result is held until the consumer takes it. Only one transaction is in
//   flight at a time.
//
// Parameter constraints
//   WIDTH must be an integer multiple of SLICE, and WIDTH/SLICE must be >= 2.
// ---------------------------------------------------------------------------

// SLICE-bit Kogge-Stone adder with carry-in. The log2(N) prefix levels are
// evaluated inside a function. The level vectors are therefore locals and do
// not form a self-referencing net.
module ksa_nbit #(
  parameter int N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         Co,
  output logic [N-1:0] S
);
  function automatic logic [N:0] ksa_calc(input logic [N-1:0] a_v,
                                          input logic [N-1:0] b_v,
                                          input logic         c_in);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] g_n;
    logic [N-1:0] p_n;
    logic [N-1:0] half_sum;
    logic [N:0]   c;
    g        = a_v & b_v;
    p        = a_v ^ b_v;
    half_sum = p;
    // After the prefix loop, g[i]/p[i] are the group generate/propagate of bits i..0.
    for (int d = 1; d < N; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < N; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    c[0] = c_in;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c_in);
    end
    return {c[N], half_sum ^ c[N-1:0]};
  endfunction

  logic [N:0] w_res;

  always_comb begin
    w_res = ksa_calc(A, B, Ci);
  end

  assign Co = w_res[N];
  assign S  = w_res[N-1:0];
endmodule

module ksa_multiword_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ksa_multiword_adder_if.slave bus,
  output logic [1:0]           o_dbg_state
);
  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = $clog2(NSLICES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_co;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_s;
  logic             w_co;

  assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

  ksa_nbit #(.N(SLICE)) u_ksa (
    .A  (w_a_slice),
    .B  (w_b_slice),
    .Ci (r_carry),
    .Co (w_co),
    .S  (w_s)
  );

  // in_ready is masked by rst. A producer therefore never sees a transfer
  // accepted on an edge where reset wins.
  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.sum       = r_sum;
  assign bus.co        = r_co;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.ci;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Slices not written yet keep stale data. They are hidden because
          // out_valid stays low until the last slice is written.
          for (int i = 0; i < NSLICES; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[i*SLICE +: SLICE] <= w_s;
            end
          end
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IDX_W'(NSLICES - 1)) begin
            r_co    <= w_co;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
